// File: rtl/lsu_obi_pkg.sv
// rtl/lsu_obi_pkg.sv - shared types for the OBI load/store unit
package lsu_obi_pkg;
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } data_type_t;
endpackage

// File: rtl/lsu_obi_multi.sv
// rtl/lsu_obi_multi.sv - load/store unit driving an OBI data port with several in-flight accesses
module lsu_obi_multi
    import lsu_obi_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_addr_i,
    input  logic             req_we_i,
    input  data_type_t       req_type_i,
    input  logic             req_sign_ext_i,
    input  logic [31:0]      req_wdata_i,
    output logic             resp_valid_o,
    output logic [31:0]      resp_rdata_o,
    output logic             resp_we_o,
    output logic             resp_misaligned_o,
    output logic             data_obi_req_o,
    input  logic             data_obi_gnt_i,
    output logic [31:0]      data_obi_addr_o,
    output logic             data_obi_we_o,
    output logic [3:0]       data_obi_be_o,
    output logic [31:0]      data_obi_wdata_o,
    input  logic             data_obi_rvalid_i,
    output logic             data_obi_rready_o,
    input  logic [31:0]      data_obi_rdata_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] outstanding_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef struct packed {
        logic       we;
        data_type_t dtype;
        logic       sign_ext;
        logic [1:0] off;
        logic       mis;
    } tag_t;

    tag_t             fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       full, empty, misaligned, push, pop;
    tag_t       head, push_tag;
    logic [31:0] shifted;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign empty = (cnt_q == '0);
    assign head  = fifo_q[rd_ptr_q];

    always_comb begin
        misaligned = 1'b0;
        case (req_type_i)
            HALF_WORD: misaligned = req_addr_i[0];
            WORD:      misaligned = (req_addr_i[1:0] != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    end

    // Misaligned requests only enter an empty queue so their error response
    // cannot overtake an earlier bus response.
    always_comb begin
        data_obi_req_o = req_valid_i && !misaligned && !full;
        if (misaligned) begin
            req_ready_o = req_valid_i && empty;
        end else begin
            req_ready_o = data_obi_req_o && data_obi_gnt_i;
        end
    end

    assign push = req_ready_o;

    always_comb begin
        push_tag.we       = req_we_i;
        push_tag.dtype    = req_type_i;
        push_tag.sign_ext = req_sign_ext_i;
        push_tag.off      = req_addr_i[1:0];
        push_tag.mis      = misaligned;
    end

    assign data_obi_addr_o   = {req_addr_i[31:2], 2'b00};
    assign data_obi_we_o     = req_we_i;
    assign data_obi_wdata_o  = req_wdata_i << {req_addr_i[1:0], 3'b000};
    assign data_obi_rready_o = 1'b1;

    always_comb begin
        case (req_type_i)
            BYTE:      data_obi_be_o = 4'b0001 << req_addr_i[1:0];
            HALF_WORD: data_obi_be_o = 4'b0011 << req_addr_i[1:0];
            default:   data_obi_be_o = 4'b1111;
        endcase
    end

    always_comb begin
        resp_valid_o = 1'b0;
        pop          = 1'b0;
        if (!empty) begin
            if (head.mis) begin
                resp_valid_o = 1'b1;
                pop          = 1'b1;
            end else begin
                resp_valid_o = data_obi_rvalid_i;
                pop          = data_obi_rvalid_i;
            end
        end
    end

    assign shifted = data_obi_rdata_i >> {head.off, 3'b000};

    always_comb begin
        resp_rdata_o = '0;
        if (resp_valid_o && !head.mis && !head.we) begin
            case (head.dtype)
                BYTE:      resp_rdata_o = {{24{head.sign_ext & shifted[7]}}, shifted[7:0]};
                HALF_WORD: resp_rdata_o = {{16{head.sign_ext & shifted[15]}}, shifted[15:0]};
                default:   resp_rdata_o = shifted;
            endcase
        end
    end

    assign resp_we_o         = resp_valid_o && head.we;
    assign resp_misaligned_o = resp_valid_o && head.mis;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_tag;
        end
    end

    assign outstanding_o = cnt_q;
    assign busy_o        = !empty || (req_valid_i && !req_ready_o);

    // A misaligned head never reached the bus, so no rvalid can belong to it.
    a_no_rvalid_on_mis: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(data_obi_rvalid_i && !empty && head.mis));

endmodule

// File: tb/tb_lsu_obi_multi.sv
// tb/tb_lsu_obi_multi.sv - directed self-checking bench for lsu_obi_multi
module tb_lsu_obi_multi;
    import lsu_obi_pkg::*;

    localparam int MAXO  = 2;
    localparam int CNT_W = $clog2(MAXO + 1);

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      req_addr_i;
    logic             req_we_i;
    data_type_t       req_type_i;
    logic             req_sign_ext_i;
    logic [31:0]      req_wdata_i;
    logic             resp_valid_o;
    logic [31:0]      resp_rdata_o;
    logic             resp_we_o;
    logic             resp_misaligned_o;
    logic             data_obi_req_o;
    logic             data_obi_gnt_i;
    logic [31:0]      data_obi_addr_o;
    logic             data_obi_we_o;
    logic [3:0]       data_obi_be_o;
    logic [31:0]      data_obi_wdata_o;
    logic             data_obi_rvalid_i;
    logic             data_obi_rready_o;
    logic [31:0]      data_obi_rdata_i;
    logic             busy_o;
    logic [CNT_W-1:0] outstanding_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    lsu_obi_multi #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_type_i(req_type_i),
        .req_sign_ext_i(req_sign_ext_i), .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
        .resp_we_o(resp_we_o), .resp_misaligned_o(resp_misaligned_o),
        .data_obi_req_o(data_obi_req_o), .data_obi_gnt_i(data_obi_gnt_i),
        .data_obi_addr_o(data_obi_addr_o), .data_obi_we_o(data_obi_we_o),
        .data_obi_be_o(data_obi_be_o), .data_obi_wdata_o(data_obi_wdata_o),
        .data_obi_rvalid_i(data_obi_rvalid_i), .data_obi_rready_o(data_obi_rready_o),
        .data_obi_rdata_i(data_obi_rdata_i),
        .busy_o(busy_o), .outstanding_o(outstanding_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic we,
                         input data_type_t t, input logic sx, input logic [31:0] wd);
        req_valid_i    = v;
        req_addr_i     = a;
        req_we_i       = we;
        req_type_i     = t;
        req_sign_ext_i = sx;
        req_wdata_i    = wd;
    endtask

    initial begin
        rst_n_i           = 1'b0;
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i    = 1'b0;
        data_obi_rvalid_i = 1'b0;
        data_obi_rdata_i  = 32'h0;
        tick(); tick();
        settle();
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        chk("rst_obi_req", 32'(data_obi_req_o), 32'd0);
        chk("rst_rready", 32'(data_obi_rready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        rst_n_i = 1'b1;

        // LB signed at 0x103
        tick();
        drive(1'b1, 32'h103, 1'b0, BYTE, 1'b1, 32'h0);
        data_obi_gnt_i = 1'b1;
        settle();
        chk("lb_req", 32'(data_obi_req_o), 32'd1);
        chk("lb_addr", data_obi_addr_o, 32'h100);
        chk("lb_be", 32'(data_obi_be_o), 32'b1000);
        chk("lb_ready", 32'(req_ready_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i    = 1'b0;
        data_obi_rvalid_i = 1'b1;
        data_obi_rdata_i  = 32'h8000_0000;
        settle();
        chk("lb_outstanding", 32'(outstanding_o), 32'd1);
        chk("lb_resp_valid", 32'(resp_valid_o), 32'd1);
        chk("lb_rdata", resp_rdata_o, 32'hFFFF_FF80);
        chk("lb_resp_we", 32'(resp_we_o), 32'd0);
        tick();
        data_obi_rvalid_i = 1'b0;
        settle();
        chk("lb_drain", 32'(outstanding_o), 32'd0);

        // SH at 0x202
        drive(1'b1, 32'h202, 1'b1, HALF_WORD, 1'b0, 32'h0000_BEEF);
        data_obi_gnt_i = 1'b1;
        settle();
        chk("sh_be", 32'(data_obi_be_o), 32'b1100);
        chk("sh_wdata", data_obi_wdata_o, 32'hBEEF_0000);
        chk("sh_we", 32'(data_obi_we_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i    = 1'b0;
        data_obi_rvalid_i = 1'b1;
        data_obi_rdata_i  = 32'hDEAD_BEEF;
        settle();
        chk("sh_resp_valid", 32'(resp_valid_o), 32'd1);
        chk("sh_resp_we", 32'(resp_we_o), 32'd1);
        chk("sh_rdata", resp_rdata_o, 32'h0);
        tick();
        data_obi_rvalid_i = 1'b0;

        // LH signed at 0x006 and LHU at 0x002
        drive(1'b1, 32'h006, 1'b0, HALF_WORD, 1'b1, 32'h0);
        data_obi_gnt_i = 1'b1;
        tick();
        drive(1'b1, 32'h002, 1'b0, HALF_WORD, 1'b0, 32'h0);
        data_obi_rvalid_i = 1'b1;
        data_obi_rdata_i  = 32'h9ABC_1234;
        settle();
        chk("lh_rdata", resp_rdata_o, 32'hFFFF_9ABC);
        tick();
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i   = 1'b0;
        data_obi_rdata_i = 32'h8765_0000;
        settle();
        chk("lhu_rdata", resp_rdata_o, 32'h0000_8765);
        tick();
        data_obi_rvalid_i = 1'b0;

        // Three back-to-back LW with two slots
        drive(1'b1, 32'h10, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i = 1'b1;
        settle();
        chk("lw1_ready", 32'(req_ready_o), 32'd1);
        tick();
        drive(1'b1, 32'h14, 1'b0, WORD, 1'b0, 32'h0);
        settle();
        chk("lw2_ready", 32'(req_ready_o), 32'd1);
        tick();
        drive(1'b1, 32'h18, 1'b0, WORD, 1'b0, 32'h0);
        settle();
        chk("lw3_held_ready", 32'(req_ready_o), 32'd0);
        chk("lw3_held_req", 32'(data_obi_req_o), 32'd0);
        chk("lw3_full", 32'(outstanding_o), 32'd2);
        chk("lw3_busy", 32'(busy_o), 32'd1);
        tick();
        data_obi_rvalid_i = 1'b1;
        data_obi_rdata_i  = 32'h1111_1111;
        settle();
        chk("lw1_rdata", resp_rdata_o, 32'h1111_1111);
        chk("lw3_no_same_cycle", 32'(req_ready_o), 32'd0);
        tick();
        data_obi_rdata_i = 32'h2222_2222;
        settle();
        chk("lw2_rdata", resp_rdata_o, 32'h2222_2222);
        chk("lw3_ready", 32'(req_ready_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i   = 1'b0;
        data_obi_rdata_i = 32'h3333_3333;
        settle();
        chk("lw3_rdata", resp_rdata_o, 32'h3333_3333);
        tick();
        data_obi_rvalid_i = 1'b0;
        settle();
        chk("lw_drain", 32'(outstanding_o), 32'd0);

        // Misaligned LW with the queue empty
        drive(1'b1, 32'h1001, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i = 1'b1;
        settle();
        chk("mis_no_req", 32'(data_obi_req_o), 32'd0);
        chk("mis_ready", 32'(req_ready_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        settle();
        chk("mis_resp_valid", 32'(resp_valid_o), 32'd1);
        chk("mis_flag", 32'(resp_misaligned_o), 32'd1);
        chk("mis_rdata", resp_rdata_o, 32'h0);
        tick();
        settle();
        chk("mis_drain", 32'(outstanding_o), 32'd0);
        chk("mis_resp_gone", 32'(resp_valid_o), 32'd0);

        // Misaligned LW behind an outstanding load
        drive(1'b1, 32'h40, 1'b0, WORD, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h1001, 1'b0, WORD, 1'b0, 32'h0);
        settle();
        chk("mis_stall_ready", 32'(req_ready_o), 32'd0);
        chk("mis_stall_req", 32'(data_obi_req_o), 32'd0);
        chk("mis_stall_busy", 32'(busy_o), 32'd1);
        tick();
        data_obi_rvalid_i = 1'b1;
        data_obi_rdata_i  = 32'h4444_4444;
        settle();
        chk("mis_prior_resp", resp_rdata_o, 32'h4444_4444);
        chk("mis_stall_on_rvalid", 32'(req_ready_o), 32'd0);
        tick();
        data_obi_rvalid_i = 1'b0;
        settle();
        chk("mis_accept", 32'(req_ready_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i = 1'b0;
        settle();
        chk("mis2_flag", 32'(resp_misaligned_o), 32'd1);
        tick();

        // SB at 0x301 with grant withheld for four cycles
        drive(1'b1, 32'h301, 1'b1, BYTE, 1'b0, 32'h0000_00A5);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("gnt_wait_addr", data_obi_addr_o, 32'h300);
            chk("gnt_wait_be", 32'(data_obi_be_o), 32'b0010);
            chk("gnt_wait_wdata", data_obi_wdata_o, 32'h0000_A500);
            chk("gnt_wait_busy", 32'(busy_o), 32'd1);
            chk("gnt_wait_cnt", 32'(outstanding_o), 32'd0);
            chk("gnt_wait_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        data_obi_gnt_i = 1'b1;
        settle();
        chk("gnt_ready", 32'(req_ready_o), 32'd1);
        tick();
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i = 1'b0;
        settle();
        chk("gnt_cnt", 32'(outstanding_o), 32'd1);
        tick();
        data_obi_rvalid_i = 1'b1;
        settle();
        chk("sb_resp_we", 32'(resp_we_o), 32'd1);
        tick();
        data_obi_rvalid_i = 1'b0;

        // Reset with two loads outstanding
        drive(1'b1, 32'h50, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i = 1'b1;
        tick();
        drive(1'b1, 32'h54, 1'b0, WORD, 1'b0, 32'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, WORD, 1'b0, 32'h0);
        data_obi_gnt_i = 1'b0;
        settle();
        chk("pre_rst_cnt", 32'(outstanding_o), 32'd2);
        rst_n_i = 1'b0;
        settle();
        chk("async_rst_cnt", 32'(outstanding_o), 32'd0);
        tick();
        rst_n_i = 1'b1;
        tick();
        data_obi_rvalid_i = 1'b1;
        data_obi_rdata_i  = 32'h5555_5555;
        settle();
        chk("stray_resp_valid", 32'(resp_valid_o), 32'd0);
        tick();
        data_obi_rvalid_i = 1'b0;
        settle();
        chk("stray_cnt", 32'(outstanding_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_obi_multi.md
Name: lsu_obi_multi

Overview:
Parametrised load/store unit. It replaces the single-outstanding memory access path of the MEM stage with an OBI data-port master that supports up to MAX_OUTSTANDING in-flight transactions. Byte and half-word accesses are aligned by address offset (lane shifting of wdata, be and rdata). Misaligned accesses are flagged without touching the bus. It sits between the EX/MEM pipeline register and the data OBI port; responses return to WB strictly in order.

Parameters:
MAX_OUTSTANDING, 2, maximum in-flight transactions including a pending misaligned entry (legal range 1..8).
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived; not overridden).

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
req_valid_i  in  1  pipeline request valid; held with a stable payload until req_ready_o
req_ready_o  out  1  request accepted this cycle
req_addr_i  in  32  byte address
req_we_i  in  1  1 = store, 0 = load
req_type_i  in  data_type_t  BYTE / HALF_WORD / WORD
req_sign_ext_i  in  1  sign-extend load data
req_wdata_i  in  32  store data, LSB-aligned
resp_valid_o  out  1  in-order response valid (single cycle; no backpressure)
resp_rdata_o  out  32  aligned, extended load data; 0 for stores and misaligned
resp_we_o  out  1  response belongs to a store
resp_misaligned_o  out  1  response is a misaligned-access error
data_obi_req_o, data_obi_gnt_i, data_obi_addr_o[32], data_obi_we_o, data_obi_be_o[4], data_obi_wdata_o[32], data_obi_rvalid_i, data_obi_rready_o, data_obi_rdata_i[32]  OBI master port
busy_o  out  1  outstanding work or a blocked request (drives pipeline stall)
outstanding_o  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset state: FIFO empty, outstanding_o = 0.
  - resp_valid_o = 0, data_obi_req_o = 0 while req_valid_i = 0.
  - data_obi_rready_o = 1 at all times.
- Misaligned request: HALF_WORD with addr[0] = 1, or WORD with addr[1:0] != 0. Otherwise the request is aligned.
- full: outstanding_o == MAX_OUTSTANDING. A same-cycle pop does not free a slot for a same-cycle push.
- Aligned request:
  - data_obi_req_o = req_valid_i && !full.
  - req_ready_o = data_obi_req_o && data_obi_gnt_i.
  - Push tag {we, type, sign_ext, addr[1:0], mis = 0} on grant.
- OBI drive:
  - addr_o = {addr[31:2], 2'b00}; we_o = req_we_i.
  - be_o: BYTE 0001 << off, HALF_WORD 0011 << off, WORD 1111.
  - wdata_o = req_wdata_i << (8*off).
- Misaligned request:
  - Never asserts data_obi_req_o.
  - Accepted (req_ready_o = 1) only when outstanding_o == 0, which guarantees in-order completion.
  - Push tag with mis = 1.
- Response pop:
  - Head tag mis = 1: resp_valid_o = 1 and resp_misaligned_o = 1 on the cycle the entry is head (one cycle after acceptance); pop.
  - Head tag mis = 0: resp_valid_o = data_obi_rvalid_i; pop on rvalid.
- Load data: shifted = rdata >> (8*off); then zero/sign-extend bits [7:0] or [15:0] per the tag; WORD passes through.
- Counter: +1 on push, -1 on pop, unchanged on both.
- Error cases:
  - rvalid while empty: ignored, no response, counter stays 0.
  - rvalid while head mis = 1: impossible by OBI rvalid-after-gnt ordering; SVA-asserted.
- busy_o = (outstanding_o != 0) || (req_valid_i && !req_ready_o).
- Reset mid-transaction: FIFO and counter cleared immediately; later stray rvalids are ignored per the empty rule.

Test Plan:
- LB signed, addr 0x103, rdata 0x80_00_00_00, gnt same cycle, rvalid next cycle -> be = 1000, obi addr 0x100, resp_rdata 0xFFFFFF80.
- SH addr 0x202, wdata 0x0000BEEF -> be = 1100, wdata_o 0xBEEF0000, resp_we = 1, resp_rdata 0.
- MAX_OUTSTANDING = 2: three back-to-back LW with gnt tied high and rvalid delayed 3 cycles -> third req held (req_ready_o = 0, req_o = 0) until the first rvalid; responses in order.
- LW addr 0x1001 with FIFO empty -> no OBI req; resp_valid_o = 1 with resp_misaligned_o = 1 the next cycle. Same request issued with one load outstanding -> stalls until that load responds.
- gnt withheld 4 cycles -> addr/be/wdata stable, busy_o = 1, outstanding_o stays 0 until grant.
- Assert rst_n_i with 2 outstanding, then rvalid after release -> outstanding_o = 0, no resp_valid_o.
